// File: rtl/and4_sweep_checker_if.sv
// Stimulus/result bundle between the AND4 sweep checker and the gate under test.
// Latency: none (plain wires).
// Backpressure: none; start is a level sampled by the checker, results are held.
interface and4_sweep_checker_if;
  logic        start;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [15:0] truth;

  // Checker side: drives the gate inputs and publishes the results.
  modport master (
    input  start, f_in,
    output a, b, c, d, busy, done, pass, err_count, truth
  );

  // Gate / controller side.
  modport slave (
    output start, f_in,
    input  a, b, c, d, busy, done, pass, err_count, truth
  );
endinterface

// File: rtl/and4_sweep_checker.sv
// Exhaustive 16-vector sweep of a 4-input AND gate with an observed truth table and mismatch count.
// Latency: done rises 16*HOLD_CYCLES edges after the edge that accepts start.
// Backpressure: none; start is ignored while a sweep runs, results are held in DONE until the next start.
module and4_sweep_checker #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  and4_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  v;
  logic [7:0]  hc;
  logic [4:0]  err_count;
  logic [15:0] truth;
  logic        sample;
  logic        accept;

  // Last edge of the hold window for the current vector.
  assign sample = (state == RUN) && (hc == HC_LAST);
  // start is only honoured when no sweep is in progress.
  assign accept = (state != RUN) && bus.start;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (sample && (v == 4'hF)) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector/hold counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= 4'd0;
      hc        <= 8'd0;
      err_count <= 5'd0;
      truth     <= 16'h0000;
    end else if (accept) begin
      v         <= 4'd0;
      hc        <= 8'd0;
      err_count <= 5'd0;
      truth     <= 16'h0000;
    end else if (sample) begin
      truth[v] <= bus.f_in;
      if (bus.f_in != (v == 4'hF)) err_count <= err_count + 5'd1;
      hc <= 8'd0;
      // Wraps 15 -> 0 on the final sample, parking the gate inputs at zero in DONE.
      v  <= v + 4'd1;
    end else if (state == RUN) begin
      hc <= hc + 8'd1;
    end
  end

  // All outputs decode flops only; no input reaches an output combinationally.
  assign bus.a         = v[0];
  assign bus.b         = v[1];
  assign bus.c         = v[2];
  assign bus.d         = v[3];
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err_count == 5'd0);
  assign bus.err_count = err_count;
  assign bus.truth     = truth;

endmodule

// File: tb/tb_and4_sweep_checker.sv
// Self-checking bench for and4_sweep_checker: real, stuck, OR and randomly faulted gates.
// Latency: checks the 16*HOLD_CYCLES sweep timing for HOLD_CYCLES of 4 and 1.
// Backpressure: exercises start during a sweep and start in DONE.
module tb_and4_sweep_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   gate_mode;      // 0 AND, 1 stuck-0, 2 stuck-1, 3 OR, 4 AND with random fault mask
  logic [15:0] fault_mask;

  and4_sweep_checker_if bus4 ();
  and4_sweep_checker_if bus1 ();

  and4_sweep_checker #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
  and4_sweep_checker #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  logic [3:0] vec4;
  logic [3:0] vec1;
  logic       f4;
  assign vec4 = {bus4.d, bus4.c, bus4.b, bus4.a};
  assign vec1 = {bus1.d, bus1.c, bus1.b, bus1.a};

  // Gate under test for the HOLD_CYCLES=4 instance.
  always_comb begin
    f4 = 1'b0;
    case (gate_mode)
      0:       f4 = &vec4;
      1:       f4 = 1'b0;
      2:       f4 = 1'b1;
      3:       f4 = |vec4;
      default: f4 = (vec4 == 4'hF) ^ fault_mask[vec4];
    endcase
  end
  assign bus4.f_in = f4;
  assign bus1.f_in = &vec1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start on the 4-cycle instance and follow the sweep to done.
  // n counts edges after the accepting edge; vector n/4 must be on the pins at each one.
  task automatic sweep4(output int n, output bit busy_ok, output bit vec_ok);
    busy_ok = 1'b1;
    vec_ok  = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    n = 0;
    while (bus4.done !== 1'b1 && n < 2000) begin
      if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) busy_ok = 1'b0;
      if (vec4 !== 4'(n / 4)) vec_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (bus4.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    gate_mode = 0;
    fault_mask = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus4.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", bus4.done); end
    checks++; if (bus4.pass !== 1'b0)  begin errors++; $display("FAIL reset_pass got %b want 0", bus4.pass); end
    checks++; if (bus4.err_count !== 5'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus4.err_count); end
    checks++; if (bus4.truth !== 16'h0000) begin errors++; $display("FAIL reset_truth got %h want 0000", bus4.truth); end
    checks++; if (vec4 !== 4'd0)       begin errors++; $display("FAIL reset_vec got %0d want 0", vec4); end
    checks++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin errors++; $display("FAIL reset_dut1 busy %b done %b want 0 0", bus1.busy, bus1.done); end
    rst = 1'b0;
  endtask

  // One sweep with a known gate; expected table from the gate rule, count = differing entries vs AND.
  task automatic test_gate(input int mode, input logic [15:0] gate_table, input string name);
    int n; bit busy_ok; bit vec_ok;
    logic [15:0] exp_truth;
    int exp_err;
    gate_mode = mode;
    exp_truth = gate_table;
    exp_err   = $countones(gate_table ^ 16'h8000);
    sweep4(n, busy_ok, vec_ok);
    checks++; if (n != 64) begin errors++; $display("FAIL %s_latency got %0d want 64", name, n); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL %s_busy got bad busy/done overlap want clean", name); end
    checks++; if (!vec_ok)  begin errors++; $display("FAIL %s_vectors got bad stepping want 4 cycles per vector", name); end
    checks++; if (bus4.truth !== exp_truth) begin errors++; $display("FAIL %s_truth got %h want %h", name, bus4.truth, exp_truth); end
    checks++; if (bus4.err_count !== 5'(exp_err)) begin errors++; $display("FAIL %s_err got %0d want %0d", name, bus4.err_count, exp_err); end
    checks++; if (bus4.pass !== (exp_err == 0)) begin errors++; $display("FAIL %s_pass got %b want %b", name, bus4.pass, exp_err == 0); end
    checks++; if (vec4 !== 4'd0) begin errors++; $display("FAIL %s_park got %0d want 0", name, vec4); end
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 4; i++) begin
      fault_mask = 16'($urandom);
      if (i == 0) fault_mask = 16'h0000;
      test_gate(4, 16'h8000 ^ fault_mask, "random");
    end
    fault_mask = 16'h0000;
  endtask

  task automatic test_reset_mid();
    int n; bit busy_ok; bit vec_ok;
    gate_mode = 0;
    @(posedge clk); #1 bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    n = 0;
    while (vec4 !== 4'd7 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (vec4 !== 4'd7) begin errors++; $display("FAIL midrst_reach got %0d want 7", vec4); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.pass !== 1'b0) begin errors++; $display("FAIL midrst_flags got %b%b%b want 000", bus4.busy, bus4.done, bus4.pass); end
    checks++; if (bus4.err_count !== 5'd0 || bus4.truth !== 16'h0000 || vec4 !== 4'd0) begin errors++; $display("FAIL midrst_data got err %0d truth %h vec %0d want 0 0000 0", bus4.err_count, bus4.truth, vec4); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus4.busy !== 1'b0 || vec4 !== 4'd0) begin errors++; $display("FAIL midrst_idle got busy %b vec %0d want 0 0", bus4.busy, vec4); end
    sweep4(n, busy_ok, vec_ok);
    checks++; if (n != 64 || !vec_ok) begin errors++; $display("FAIL midrst_restart got latency %0d vec_ok %b want 64 1", n, vec_ok); end
    checks++; if (bus4.truth !== 16'h8000 || bus4.pass !== 1'b1) begin errors++; $display("FAIL midrst_result got %h pass %b want 8000 1", bus4.truth, bus4.pass); end
  endtask

  task automatic test_start_in_run();
    int n;
    gate_mode = 0;
    @(posedge clk); #1 bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    n = 0;
    while (bus4.done !== 1'b1 && n < 2000) begin
      if (n == 10 || n == 37) bus4.start = 1'b1;
      else bus4.start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus4.start = 1'b0;
    checks++; if (n != 64) begin errors++; $display("FAIL run_start_latency got %0d want 64", n); end
    checks++; if (bus4.truth !== 16'h8000 || bus4.err_count !== 5'd0) begin errors++; $display("FAIL run_start_result got %h %0d want 8000 0", bus4.truth, bus4.err_count); end
  endtask

  task automatic test_back_to_back();
    int n;
    checks++; if (bus4.done !== 1'b1) begin errors++; $display("FAIL b2b_pre got done %b want 1", bus4.done); end
    bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    checks++; if (bus4.done !== 1'b0 || bus4.pass !== 1'b0 || bus4.busy !== 1'b1) begin errors++; $display("FAIL b2b_edge got done %b pass %b busy %b want 0 0 1", bus4.done, bus4.pass, bus4.busy); end
    checks++; if (vec4 !== 4'd0 || bus4.truth !== 16'h0000 || bus4.err_count !== 5'd0) begin errors++; $display("FAIL b2b_clear got vec %0d truth %h err %0d want 0 0000 0", vec4, bus4.truth, bus4.err_count); end
    n = 0;
    while (bus4.done !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (n != 64 || bus4.pass !== 1'b1) begin errors++; $display("FAIL b2b_second got latency %0d pass %b want 64 1", n, bus4.pass); end
  endtask

  task automatic test_hold1();
    int n;
    bit vec_ok;
    vec_ok = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    n = 0;
    while (bus1.done !== 1'b1 && n < 500) begin
      if (vec1 !== 4'(n)) vec_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL hold1_latency got %0d want 16", n); end
    checks++; if (!vec_ok) begin errors++; $display("FAIL hold1_vectors got bad stepping want 1 cycle per vector"); end
    checks++; if (bus1.truth !== 16'h8000 || bus1.pass !== 1'b1 || bus1.err_count !== 5'd0) begin errors++; $display("FAIL hold1_result got %h pass %b err %0d want 8000 1 0", bus1.truth, bus1.pass, bus1.err_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_gate(0, 16'h8000, "and");
    test_gate(1, 16'h0000, "tied0");
    test_gate(2, 16'hFFFF, "tied1");
    test_gate(3, 16'hFFFE, "or");
    test_random_faults();
    test_reset_mid();
    test_start_in_run();
    test_back_to_back();
    test_hold1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and4_sweep_checker.md
# and4_sweep_checker

Self-checking exhaustive stimulus stage for the 4-input AND gate. On `start` it drives all 16 input combinations onto `a`, `b`, `c` and `d`, which connect directly to `and4gate`. For each combination it samples the gate's output `f`, compares it with the expected AND result, and records a 16-bit observed truth table and a mismatch count. It replaces hand-written delay-based stimulus with a clocked, synthesizable sweep that can also run on the board.

## Interface
- `HOLD_CYCLES`, default 4: clock cycles each vector is held before `f` is sampled; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE.
- `f_in`  in  1  output of the gate under test.
- `a`, `b`, `c`, `d`  out  1 each  gate inputs; `{d,c,b,a}` = current vector index.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next `start` or `rst`.
- `pass`  out  1  valid when `done`=1; equals (`err_count`==0).
- `err_count`  out  5  number of mismatching vectors, 0..16.
- `truth`  out  16  bit v holds the `f_in` value sampled for vector v.

## Operation
- States:
  - IDLE: nothing running.
  - RUN: vector v driven, hold counter `hc` active.
  - DONE: sweep finished, results held.
- Reset, with `rst`=1 sampled at any edge and in any state:
  - Next state is IDLE.
  - `v`=0, `hc`=0, so `a`..`d`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `truth`=16'h0000.
  - `rst` has priority over `start`.
- IDLE or DONE with `start`=1:
  - Next state is RUN, with `v`=0 and `hc`=0.
  - `err_count` and `truth` are cleared, `done`=0, `pass`=0, `busy`=1.
- RUN:
  - `{d,c,b,a}` = `v`, held steady for `HOLD_CYCLES` cycles.
  - When `hc` < `HOLD_CYCLES`-1, `hc` increments.
  - When `hc` = `HOLD_CYCLES`-1, this is the sample edge:
    - `truth[v]` <= `f_in`.
    - If `f_in` != (`v`==15), `err_count` increments.
    - `hc` <= 0.
    - If `v`=15: next state DONE, `busy`=0, `done`=1, `pass`=(final `err_count`==0). The final count includes the vector-15 compare. `v` returns to 0, so `a`..`d`=0.
    - Otherwise `v` increments.
- `start` during RUN is ignored.
- DONE holds all results until `start` or `rst`.
- Arithmetic:
  - `v` is 4 bits.
  - `hc` is 8 bits.
  - `err_count` is 5 bits and cannot overflow, since the maximum is 16.
  - The expected output is the AND of the four driven bits. Only vector 15 expects 1.

## Timing
- The edge that accepts `start` makes vector 0 visible on `a`..`d` and asserts `busy`.
- Vector v is visible for exactly `HOLD_CYCLES` cycles. `f_in` is sampled at the last edge of that window.
  - The gate is combinational, so `f_in` settles within the window.
  - With `HOLD_CYCLES`=1, `f_in` is sampled in the same cycle the vector is driven.
- Sweep latency: `done` rises exactly 16×`HOLD_CYCLES` edges after the edge that accepted `start`. That is 64 edges at the default.
- `busy` and `done` are never high together. `busy` falls on the same edge that `done` rises.
- A `start` accepted in DONE clears `done` and `pass` on that same edge. There is no idle cycle between sweeps.
- `rst` mid-sweep aborts the sweep. Outputs take their reset values on that edge, and partial results are discarded.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Real `and4gate` connected, `HOLD_CYCLES`=4, pulse `start`:
  - `busy` is high for 64 cycles, then `done`=1.
  - `pass`=1, `err_count`=0, `truth`=16'h8000.
  - `{d,c,b,a}` steps through 0..15, 4 cycles per step.
- `f_in` tied to 0: `done` after 64 cycles, `err_count`=1, `truth`=16'h0000, `pass`=0.
- `f_in` tied to 1: `err_count`=15, `truth`=16'hFFFF, `pass`=0.
- OR gate substituted: `err_count`=14, `truth`=16'hFFFE, `pass`=0.
- Reset mid-sweep, then restart with the real gate:
  - Assert `rst` for one cycle while `v`=7.
  - On the next edge all outputs are 0 and the state is IDLE.
  - A new `start` gives the full result of the first test.
- `start` handling:
  - `start` re-pulsed while `busy` has no effect: `done` still comes 64 cycles after the first `start`.
  - `start` in DONE drops `done` on the same edge and restarts from vector 0.
  - `HOLD_CYCLES`=1: `done` comes 16 cycles after `start`.
